// File: rtl/satadd_pkg.sv
// Shared definitions for the saturating-adder operand loader, result stage and LED decoder.
package satadd_pkg;

  localparam int unsigned DEF_WIDTH       = 12;
  localparam int unsigned DEF_MODE_W      = 2;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned STATE_W         = 2;

  // Encoding is fixed: it is driven straight onto the LED state code.
  typedef enum logic [STATE_W-1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_MODE  = 2'd2,
    S_VALID = 2'd3
  } state_t;

endpackage

// File: rtl/satadd_loader_sync_edge.sv
// Button synchronizer with rising-edge detector: one single-cycle pulse per press.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_async,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the asynchronous level through the chain and remember the last synchronized sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/satadd_loader.sv
// Operand-entry stage: captures a, b and mode from the switches, one per button press,
// then holds the set under a valid/ready handshake until downstream accepts it.
module satadd_loader
  import satadd_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned MODE_W      = DEF_MODE_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   sw,
  input  logic               btn,
  input  logic               clr,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [MODE_W-1:0]  mode,
  output logic               out_valid,
  output logic [STATE_W-1:0] state
);

  logic              load_pulse;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              valid_q, valid_d;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .d_async(btn),
    .pulse  (load_pulse)
  );

  // State and operand registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and capture logic; clr overrides both presses and handshakes.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    if (clr) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      mode_d  = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_A: begin
          if (load_pulse) begin
            a_d     = sw;
            state_d = S_B;
          end
        end
        S_B: begin
          if (load_pulse) begin
            b_d     = sw;
            state_d = S_MODE;
          end
        end
        S_MODE: begin
          if (load_pulse) begin
            mode_d  = sw[MODE_W-1:0];
            valid_d = 1'b1;
            state_d = S_VALID;
          end
        end
        S_VALID: begin
          // Presses are ignored here, even on the accepting edge.
          if (out_ready) begin
            valid_d = 1'b0;
            state_d = S_A;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign mode      = mode_q;
  assign out_valid = valid_q;
  assign state     = STATE_W'(state_q);

endmodule

// File: doc/satadd_loader.md
Name: satadd_loader

Overview:
Upstream operand-entry stage for the 12-bit saturating adder.
- Captures `a`, `b` and `mode` in turn from the board switches, one value per press of the load button.
- Holds the completed operand set stable with a valid/ready handshake until the downstream satadd result stage accepts it.
- Provides a state code for board LEDs so the user sees which operand is loaded next.

Parameters:
- WIDTH, 12, operand width for `a`, `b` and `sw`.
- MODE_W, 2, width of the `mode` field, taken from `sw[MODE_W-1:0]`.
- SYNC_STAGES, 2, flops in the button synchronizer (minimum 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sw  input  WIDTH  switch value; assumed quasi-static, sampled directly.
- btn  input  1  load button level; externally debounced, asynchronous to clk.
- clr  input  1  synchronous clear, active-high.
- out_ready  input  1  downstream accepts the operand set.
- a  output  WIDTH  operand A to satadd.
- b  output  WIDTH  operand B to satadd.
- mode  output  MODE_W  mode to satadd.
- out_valid  output  1  `a`, `b` and `mode` form a complete set.
- state  output  2  current FSM state code for LEDs.

Behaviour:
- Reset is asynchronous and active-low on `reset_n`, with a single clock `clk`.
- While `reset_n` is low: `a`=0, `b`=0, `mode`=0, `out_valid`=0, `state`=S_A, and all synchronizer and edge flops are 0.
- Button synchronizer:
  - `btn` passes through SYNC_STAGES flops.
  - load_pulse = last sync flop high AND previous-sample flop low.
  - A press produces exactly one single-cycle pulse regardless of how long it is held.
  - With `btn` rising before edge 1, the pulse is high in the cycle after edge SYNC_STAGES, and capture occurs at edge SYNC_STAGES+1.
  - A button already high when reset deasserts yields one pulse after release.
- FSM states (encoding fixed, also driven on `state`):
  - S_A (2'd0): load_pulse → `a` <= `sw`, go to S_B.
  - S_B (2'd1): load_pulse → `b` <= `sw`, go to S_MODE.
  - S_MODE (2'd2): load_pulse → `mode` <= `sw[MODE_W-1:0]`, `out_valid` <= 1, go to S_VALID.
  - S_VALID (2'd3):
    - `out_valid` is held at 1; `a`, `b` and `mode` do not change.
    - On a clk edge with `out_ready`=1: `out_valid` <= 0, go to S_A.
    - load_pulse is ignored in this state.
- Handshake:
  - Transfer occurs on the edge where `out_valid` and `out_ready` are both 1.
  - `out_valid` never deasserts without a transfer, except on clr or reset.
  - `out_ready` has no effect outside S_VALID.
- Registered outputs:
  - `a`, `b` and `mode` keep their last values after transfer until overwritten in the next pass.
  - This lets the downstream stage keep displaying the last result.
- clr:
  - On the next edge: state <= S_A, `out_valid` <= 0, `a`/`b`/`mode` <= 0.
  - Synchronizer flops are unaffected.
- Simultaneous events:
  - clr together with load_pulse: clr wins, nothing is captured.
  - clr together with a handshake in S_VALID: clr wins; the transfer is still counted by downstream because `out_valid`=`out_ready`=1 on that edge.
  - `out_ready` together with load_pulse in S_VALID: transfer completes, and the pulse is discarded, not captured into `a`.
- Reset mid-operation abandons partial entry; the next press loads `a`.
- No arithmetic is performed here; values pass through bit-exact.

Decomposition:
- Package `satadd_pkg` holds:
  - WIDTH and MODE_W defaults.
  - State encoding localparams S_A, S_B, S_MODE, S_VALID.
  - These are shared with the downstream result stage and the LED decoder.
- Sub-module `sync_edge` (parameter SYNC_STAGES; ports clk, reset_n, d_async, pulse) contains the synchronizer and rising-edge detector.

Test Plan:
- Load sequence: presses with `sw`=12'h7FF, then 12'h001, then 12'h001, `out_ready`=0 → `a`=7FF, `b`=001, `mode`=1, `out_valid`=1, `state`=3, each capture at SYNC_STAGES+1 edges after its `btn` rise.
- Hold `out_ready`=0 for 20 cycles while changing `sw` to 12'hABC and pressing `btn` → `a`, `b`, `mode` and `out_valid` unchanged. Then pulse `out_ready` for 1 cycle → `out_valid`=0, `state`=0 on the following cycle, and `a` still 7FF.
- Hold `btn` high for 50 cycles in S_A with `sw`=12'h800 → exactly one capture (`a`=800), `state`=1 and remains 1.
- Assert clr in S_B after `a`=12'h123 is loaded → `state`=0, `a`=0, `out_valid`=0. The next press loads `a`.
- Drop `reset_n` for 3 cycles while in S_MODE → all outputs 0 immediately (asynchronous), `state`=0 after release.
- In S_VALID, raise `out_ready` on the same cycle load_pulse is high with `sw`=12'h555 → transfer occurs, `state`=0, `a` not 555.
